// File: rtl/branch_update_queue_pkg.sv
// Shared constants and entry format for the in-flight branch queue.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package branch_update_queue_pkg;

    localparam logic [6:0]  OPC_BRANCH    = 7'b1100011;
    localparam logic [31:0] INSN_LEN_STD  = 32'd4;
    localparam logic [31:0] INSN_LEN_C    = 32'd2;
    localparam int          UPD_TAKEN_BIT = 0;

    typedef struct packed {
        logic [31:1] pc;
        logic        c;
        logic        pred_taken;
        logic        actual_taken;
        logic [31:0] target;
    } bq_entry_t;

    function automatic logic [31:0] bq_upd_pc(input bq_entry_t e);
        logic [31:0] pc_o;
        pc_o = {e.pc, 1'b0};
        pc_o[UPD_TAKEN_BIT] = e.actual_taken;
        return pc_o;
    endfunction

    function automatic logic [31:0] bq_redirect_pc(input bq_entry_t e);
        return e.actual_taken ? e.target
                              : {e.pc, 1'b0} + (e.c ? INSN_LEN_C : INSN_LEN_STD);
    endfunction

endpackage

// File: rtl/bq_entry_array.sv
// Branch entry storage with parallel tag-match resolution.
// Latency: writes visible one cycle after the enabling edge.
// Backpressure: none; the caller gates every enable with the global ready.
module bq_entry_array
    import branch_update_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TAG_W = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             clear_en,
    input  logic             alloc_en,
    input  logic [PTR_W-1:0] alloc_idx,
    input  bq_entry_t        alloc_dat,
    input  logic [TAG_W-1:0] alloc_tag,
    input  logic             res_en,
    input  logic [TAG_W-1:0] res_tag,
    input  logic             res_taken,
    input  logic [31:0]      res_target,
    input  logic             pop_en,
    input  logic [PTR_W-1:0] head_idx,
    output logic             head_vld,
    output logic             head_resolved,
    output bq_entry_t        head_dat
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] resolved_q, resolved_d;
    bq_entry_t        ent_q [DEPTH];
    bq_entry_t        ent_d [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [TAG_W-1:0] tag_d [DEPTH];

    always_comb begin
        valid_d    = valid_q;
        resolved_d = resolved_q;
        ent_d      = ent_q;
        tag_d      = tag_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (res_en && valid_q[i] && !resolved_q[i] && tag_q[i] == res_tag) begin
                resolved_d[i]         = 1'b1;
                ent_d[i].actual_taken = res_taken;
                ent_d[i].target       = res_target;
            end
        end
        if (pop_en) begin
            valid_d[head_idx]    = 1'b0;
            resolved_d[head_idx] = 1'b0;
        end
        // Allocation wins over a same-cycle resolution of the slot being written.
        if (alloc_en) begin
            valid_d[alloc_idx]    = 1'b1;
            resolved_d[alloc_idx] = 1'b0;
            ent_d[alloc_idx]      = alloc_dat;
            tag_d[alloc_idx]      = alloc_tag;
        end
        if (clear_en) begin
            valid_d    = '0;
            resolved_d = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q    <= '0;
            resolved_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            resolved_q <= resolved_d;
            ent_q      <= ent_d;
            tag_q      <= tag_d;
        end
    end

    assign head_vld      = valid_q[head_idx];
    assign head_resolved = resolved_q[head_idx];
    assign head_dat      = ent_q[head_idx];

endmodule

// File: rtl/branch_update_queue.sv
// In-order queue of in-flight branches: retires to the predictor, flags mispredicts.
// Latency: resolution at edge t pops at t+1; update/redirect pulses in the following cycle.
// Backpressure: alloc_ready_out low when full; rdy_in low freezes all state.
module branch_update_queue
    import branch_update_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             alloc_valid_in,
    input  logic [31:0]      alloc_pc_in,
    input  logic             alloc_c_in,
    input  logic             alloc_pred_taken_in,
    input  logic [TAG_W-1:0] alloc_tag_in,
    output logic             alloc_ready_out,
    input  logic             res_valid_in,
    input  logic [TAG_W-1:0] res_tag_in,
    input  logic             res_taken_in,
    input  logic [31:0]      res_target_in,
    input  logic             flush_in,
    output logic             upd_valid_out,
    output logic [31:0]      upd_pc_out,
    output logic             mispredict_out,
    output logic [31:0]      redirect_pc_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             upd_valid_q, upd_valid_d;
    logic [31:0]      upd_pc_q, upd_pc_d;
    logic             mispredict_q, mispredict_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;

    logic      head_vld, head_resolved;
    bq_entry_t head_dat, alloc_dat;
    logic      pop_en, mis_en, clear_en, alloc_en, res_en;
    logic      unused_pc_lsb;

    assign unused_pc_lsb   = alloc_pc_in[0];
    assign alloc_ready_out = (count_q != FULL_CNT);

    always_comb begin
        alloc_dat              = '0;
        alloc_dat.pc           = alloc_pc_in[31:1];
        alloc_dat.c            = alloc_c_in;
        alloc_dat.pred_taken   = alloc_pred_taken_in;
    end

    always_comb begin
        pop_en        = rdy_in && !flush_in && head_vld && head_resolved;
        mis_en        = pop_en && (head_dat.actual_taken != head_dat.pred_taken);
        // A mispredict makes every younger entry wrong-path, so it clears like a flush.
        clear_en      = rdy_in && (flush_in || mis_en);
        alloc_en      = rdy_in && alloc_valid_in && alloc_ready_out && !clear_en;
        res_en        = rdy_in && res_valid_in && !flush_in;

        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        upd_valid_d   = 1'b0;
        upd_pc_d      = upd_pc_q;
        mispredict_d  = 1'b0;
        redirect_pc_d = redirect_pc_q;

        if (pop_en) begin
            upd_valid_d = 1'b1;
            upd_pc_d    = bq_upd_pc(head_dat);
        end
        if (mis_en) begin
            mispredict_d  = 1'b1;
            redirect_pc_d = bq_redirect_pc(head_dat);
        end
        if (clear_en) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (rdy_in) begin
            head_d  = head_q + PTR_W'(pop_en);
            tail_d  = tail_q + PTR_W'(alloc_en);
            count_d = count_q + CNT_W'(alloc_en) - CNT_W'(pop_en);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= '0;
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            upd_valid_q   <= upd_valid_d;
            upd_pc_q      <= upd_pc_d;
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign upd_valid_out   = upd_valid_q;
    assign upd_pc_out      = upd_pc_q;
    assign mispredict_out  = mispredict_q;
    assign redirect_pc_out = redirect_pc_q;

    bq_entry_array #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_entries (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .clear_en      (clear_en),
        .alloc_en      (alloc_en),
        .alloc_idx     (tail_q),
        .alloc_dat     (alloc_dat),
        .alloc_tag     (alloc_tag_in),
        .res_en        (res_en),
        .res_tag       (res_tag_in),
        .res_taken     (res_taken_in),
        .res_target    (res_target_in),
        .pop_en        (pop_en),
        .head_idx      (head_q),
        .head_vld      (head_vld),
        .head_resolved (head_resolved),
        .head_dat      (head_dat)
    );

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed bench for branch_update_queue with hand-computed expectations.
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_branch_update_queue;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        alloc_valid_in;
    logic [31:0] alloc_pc_in;
    logic        alloc_c_in;
    logic        alloc_pred_taken_in;
    logic [3:0]  alloc_tag_in;
    logic        alloc_ready_out;
    logic        res_valid_in;
    logic [3:0]  res_tag_in;
    logic        res_taken_in;
    logic [31:0] res_target_in;
    logic        flush_in;
    logic        upd_valid_out;
    logic [31:0] upd_pc_out;
    logic        mispredict_out;
    logic [31:0] redirect_pc_out;

    int errors = 0;
    int checks = 0;

    branch_update_queue #(.DEPTH(8), .TAG_W(4)) dut (
        .clk_in              (clk_in),
        .rst_n_in            (rst_n_in),
        .rdy_in              (rdy_in),
        .alloc_valid_in      (alloc_valid_in),
        .alloc_pc_in         (alloc_pc_in),
        .alloc_c_in          (alloc_c_in),
        .alloc_pred_taken_in (alloc_pred_taken_in),
        .alloc_tag_in        (alloc_tag_in),
        .alloc_ready_out     (alloc_ready_out),
        .res_valid_in        (res_valid_in),
        .res_tag_in          (res_tag_in),
        .res_taken_in        (res_taken_in),
        .res_target_in       (res_target_in),
        .flush_in            (flush_in),
        .upd_valid_out       (upd_valid_out),
        .upd_pc_out          (upd_pc_out),
        .mispredict_out      (mispredict_out),
        .redirect_pc_out     (redirect_pc_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        alloc_valid_in = 1'b0;
        res_valid_in   = 1'b0;
        flush_in       = 1'b0;
    endtask

    task automatic alloc(input logic [31:0] pc, input logic c, input logic pred, input logic [3:0] tag);
        alloc_valid_in      = 1'b1;
        alloc_pc_in         = pc;
        alloc_c_in          = c;
        alloc_pred_taken_in = pred;
        alloc_tag_in        = tag;
    endtask

    task automatic resolve(input logic [3:0] tag, input logic taken, input logic [31:0] target);
        res_valid_in  = 1'b1;
        res_tag_in    = tag;
        res_taken_in  = taken;
        res_target_in = target;
    endtask

    initial begin
        rst_n_in = 1'b0;
        rdy_in   = 1'b1;
        alloc_pc_in = '0; alloc_c_in = 1'b0; alloc_pred_taken_in = 1'b0; alloc_tag_in = '0;
        res_tag_in = '0; res_taken_in = 1'b0; res_target_in = '0;
        idle();
        #2;
        chk("reset_ready", 32'(alloc_ready_out), 32'd1);
        chk("reset_upd_valid", 32'(upd_valid_out), 32'd0);
        chk("reset_mispredict", 32'(mispredict_out), 32'd0);
        chk("reset_upd_pc", upd_pc_out, 32'h0);
        chk("reset_redirect", redirect_pc_out, 32'h0);
        tick();
        rst_n_in = 1'b1;
        tick();

        // Correct taken prediction
        alloc(32'h100, 1'b0, 1'b1, 4'd3);
        tick();
        idle();
        resolve(4'd3, 1'b1, 32'h0F0);
        tick();
        chk("t2_no_early_pop", 32'(upd_valid_out), 32'd0);
        idle();
        tick();
        chk("t2_upd_valid", 32'(upd_valid_out), 32'd1);
        chk("t2_upd_pc", upd_pc_out, 32'h101);
        chk("t2_no_mispredict", 32'(mispredict_out), 32'd0);
        tick();
        chk("t2_pulse_ends", 32'(upd_valid_out), 32'd0);
        chk("t2_count", 32'(dut.count_q), 32'd0);

        // Mispredicted not-taken, younger entry discarded
        alloc(32'h200, 1'b1, 1'b0, 4'd5);
        tick();
        alloc(32'h202, 1'b0, 1'b0, 4'd6);
        tick();
        idle();
        resolve(4'd5, 1'b1, 32'h180);
        tick();
        idle();
        tick();
        chk("t3_upd_valid", 32'(upd_valid_out), 32'd1);
        chk("t3_upd_pc", upd_pc_out, 32'h201);
        chk("t3_mispredict", 32'(mispredict_out), 32'd1);
        chk("t3_redirect", redirect_pc_out, 32'h180);
        chk("t3_count", 32'(dut.count_q), 32'd0);
        resolve(4'd6, 1'b0, 32'h0);
        tick();
        idle();
        chk("t3_mispredict_ends", 32'(mispredict_out), 32'd0);
        tick();
        chk("t3_no_second_upd", 32'(upd_valid_out), 32'd0);

        // Mispredicted taken -> fall-through redirect
        alloc(32'h300, 1'b0, 1'b1, 4'd7);
        tick();
        idle();
        resolve(4'd7, 1'b0, 32'h400);
        tick();
        idle();
        tick();
        chk("t4_upd_pc", upd_pc_out, 32'h300);
        chk("t4_mispredict", 32'(mispredict_out), 32'd1);
        chk("t4_redirect", redirect_pc_out, 32'h304);
        tick();

        // Out-of-order resolution retires in order
        alloc(32'h10, 1'b0, 1'b1, 4'd1);
        tick();
        alloc(32'h20, 1'b0, 1'b1, 4'd2);
        tick();
        idle();
        resolve(4'd2, 1'b1, 32'h99);
        tick();
        resolve(4'd1, 1'b1, 32'h88);
        tick();
        chk("t5_younger_held", 32'(upd_valid_out), 32'd0);
        idle();
        tick();
        chk("t5_first_valid", 32'(upd_valid_out), 32'd1);
        chk("t5_first_pc", upd_pc_out, 32'h11);
        tick();
        chk("t5_second_valid", 32'(upd_valid_out), 32'd1);
        chk("t5_second_pc", upd_pc_out, 32'h21);
        chk("t5_second_no_mis", 32'(mispredict_out), 32'd0);
        idle();
        tick();
        chk("t5_drained", 32'(dut.count_q), 32'd0);

        // Full, stall, flush
        for (int i = 0; i < 8; i++) begin
            alloc(32'h1000 + 32'(i * 4), 1'b0, 1'b0, 4'(8 + i));
            tick();
        end
        idle();
        chk("t6_full_ready", 32'(alloc_ready_out), 32'd0);
        alloc(32'h2000, 1'b0, 1'b0, 4'd0);
        tick();
        idle();
        chk("t6_ninth_ignored", 32'(dut.count_q), 32'd8);
        rdy_in = 1'b0;
        resolve(4'd8, 1'b0, 32'h0);
        tick();
        idle();
        tick();
        chk("t6_stall_no_pop", 32'(upd_valid_out), 32'd0);
        chk("t6_stall_count", 32'(dut.count_q), 32'd8);
        rdy_in = 1'b1;
        resolve(4'd8, 1'b0, 32'h0);
        tick();
        idle();
        tick();
        chk("t6_head_pops", 32'(upd_valid_out), 32'd1);
        chk("t6_head_pc", upd_pc_out, 32'h1000);
        chk("t6_count_after_pop", 32'(dut.count_q), 32'd7);
        resolve(4'd9, 1'b0, 32'h0);
        tick();
        idle();
        rdy_in = 1'b0;
        tick();
        chk("t6_frozen_pulse", 32'(upd_valid_out), 32'd0);
        chk("t6_frozen_count", 32'(dut.count_q), 32'd7);
        rdy_in   = 1'b1;
        flush_in = 1'b1;
        alloc(32'h3000, 1'b0, 1'b0, 4'd1);
        tick();
        idle();
        chk("t6_flush_count", 32'(dut.count_q), 32'd0);
        chk("t6_flush_no_upd", 32'(upd_valid_out), 32'd0);
        chk("t6_flush_ready", 32'(alloc_ready_out), 32'd1);

        // Asynchronous reset mid-cycle while full
        for (int i = 0; i < 8; i++) begin
            alloc(32'h4000 + 32'(i * 4), 1'b0, 1'b0, 4'(i));
            tick();
        end
        idle();
        chk("t1_full_before_reset", 32'(alloc_ready_out), 32'd0);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("t1_async_ready", 32'(alloc_ready_out), 32'd1);
        chk("t1_async_count", 32'(dut.count_q), 32'd0);
        chk("t1_async_upd", 32'(upd_valid_out), 32'd0);
        chk("t1_async_mis", 32'(mispredict_out), 32'd0);
        tick();
        rst_n_in = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
